// File: rtl/dsp_mac_seq_if.sv
// dsp_mac_seq_if -- bundle of every non-clock signal of dsp_mac_seq.
//
// Groups:
//   control  : start, len, abort, busy
//   operands : op_valid/op_ready handshake carrying signed op_a, op_b
//   result   : res_valid/res_ready handshake carrying the 48-bit res_p
//   slice    : dsp_a, dsp_b, dsp_opmode, clock enables, dsp_rstp, and dsp_p back
//
// Modports:
//   slave  : the sequencer (dsp_mac_seq) view
//   master : the host plus DSP slice view (drives commands/operands and dsp_p)
interface dsp_mac_seq_if;
    logic               start;
    logic [7:0]         len;
    logic               abort;
    logic               busy;

    logic               op_valid;
    logic               op_ready;
    logic signed [17:0] op_a;
    logic signed [17:0] op_b;

    logic               res_valid;
    logic               res_ready;
    logic [47:0]        res_p;

    logic signed [17:0] dsp_a;
    logic signed [17:0] dsp_b;
    logic [7:0]         dsp_opmode;
    logic               dsp_cea;
    logic               dsp_ceb;
    logic               dsp_cem;
    logic               dsp_ceopmode;
    logic               dsp_cep;
    logic               dsp_rstp;
    logic [47:0]        dsp_p;

    modport slave (
        input  start, len, abort, op_valid, op_a, op_b, res_ready, dsp_p,
        output busy, op_ready, res_valid, res_p,
        output dsp_a, dsp_b, dsp_opmode, dsp_cea, dsp_ceb, dsp_cem, dsp_ceopmode,
        output dsp_cep, dsp_rstp
    );

    modport master (
        output start, len, abort, op_valid, op_a, op_b, res_ready, dsp_p,
        input  busy, op_ready, res_valid, res_p,
        input  dsp_a, dsp_b, dsp_opmode, dsp_cea, dsp_ceb, dsp_cem, dsp_ceopmode,
        input  dsp_cep, dsp_rstp
    );
endinterface

// File: rtl/dsp_mac_seq.sv
// dsp_mac_seq -- sequences a pipelined DSP multiply-accumulate slice through one dot product.
//
// A host starts an operation with a pair count; operand pairs are streamed through a
// valid/ready handshake straight onto the slice A/B inputs. A shadow pipeline of slots
// {v, first} tracks each pair through the slice so that the OPMODE (clear vs accumulate)
// and the P clock enable line up with the product when it arrives. Once the last product
// has landed in P the sum is captured and presented on a valid/ready result port.
//
// Parameters:
//   LAT       : cycles from a pair on dsp_a/dsp_b to its product loaded into P (3..8)
//   OPM_FIRST : slice OPMODE for the first product (P = M)
//   OPM_ACC   : slice OPMODE for later products (P = P + M)
//
// Ports:
//   clk  : rising-edge clock
//   rstn : synchronous active-low reset
//   bus  : dsp_mac_seq_if.slave (control, operand stream, result stream, slice wiring)
module dsp_mac_seq #(
    parameter int unsigned LAT       = 4,
    parameter logic [7:0]  OPM_FIRST = 8'h01,
    parameter logic [7:0]  OPM_ACC   = 8'h09
) (
    input logic          clk,
    input logic          rstn,
    dsp_mac_seq_if.slave bus
);

    typedef enum logic [2:0] {
        StIdle,
        StClr,
        StRun,
        StDrain,
        StDone
    } state_e;

    state_e           state_q, state_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [7:0]       len_q, len_d;
    logic [LAT-1:0]   slot_v_q, slot_v_d;
    logic [LAT-1:0]   slot_first_q, slot_first_d;
    logic [47:0]      res_p_q, res_p_d;

    logic             op_ready;
    logic             hs;
    logic             abort_hit;
    logic             active;

    // Operand acceptance. The count check is redundant with the move to DRAIN on the
    // last handshake, but keeps op_ready honest if len ever changes meaning.
    always_comb begin
        op_ready  = (state_q == StRun) && (cnt_q < len_q);
        hs        = bus.op_valid && op_ready;
        abort_hit = bus.abort && (state_q != StIdle);
        active    = (state_q == StClr) || (state_q == StRun) || (state_q == StDrain);
    end

    // Next-state logic.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        len_d        = len_q;
        res_p_d      = res_p_q;
        // Slots advance every cycle; only a RUN handshake inserts a valid one.
        slot_v_d     = {slot_v_q[LAT-2:0], 1'b0};
        slot_first_d = {slot_first_q[LAT-2:0], 1'b0};

        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    len_d = bus.len;
                    if (bus.len == 8'd0) begin
                        res_p_d = '0;
                        state_d = StDone;
                    end else begin
                        state_d = StClr;
                    end
                end
            end

            StClr: begin
                cnt_d   = 8'd0;
                state_d = StRun;
            end

            StRun: begin
                slot_v_d[0]     = hs;
                slot_first_d[0] = hs && (cnt_q == 8'd0);
                if (hs) begin
                    cnt_d = cnt_q + 8'd1;
                    if ((cnt_q + 8'd1) == len_q) begin
                        state_d = StDrain;
                    end
                end
            end

            StDrain: begin
                // No valid slot left means the last product was written into P on the
                // previous edge, so dsp_p is final now.
                if (slot_v_q == '0) begin
                    res_p_d = bus.dsp_p;
                    state_d = StDone;
                end
            end

            StDone: begin
                if (bus.res_ready) begin
                    state_d = StIdle;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase

        // Abort beats everything else, including a same-cycle handshake.
        if (abort_hit) begin
            state_d      = StIdle;
            cnt_d        = 8'd0;
            res_p_d      = '0;
            slot_v_d     = '0;
            slot_first_d = '0;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q      <= StIdle;
            cnt_q        <= 8'd0;
            len_q        <= 8'd0;
            slot_v_q     <= '0;
            slot_first_q <= '0;
            res_p_q      <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            len_q        <= len_d;
            slot_v_q     <= slot_v_d;
            slot_first_q <= slot_first_d;
            res_p_q      <= res_p_d;
        end
    end

    // Outputs. While rstn is low everything is forced quiet except the P reset, so the
    // slice is cleared even if the reset lands mid-operation.
    always_comb begin
        bus.busy         = 1'b0;
        bus.op_ready     = 1'b0;
        bus.res_valid    = 1'b0;
        bus.res_p        = '0;
        bus.dsp_a        = '0;
        bus.dsp_b        = '0;
        bus.dsp_opmode   = 8'h00;
        bus.dsp_cea      = 1'b0;
        bus.dsp_ceb      = 1'b0;
        bus.dsp_cem      = 1'b0;
        bus.dsp_ceopmode = 1'b0;
        bus.dsp_cep      = 1'b0;
        bus.dsp_rstp     = 1'b1;

        if (rstn) begin
            bus.busy      = (state_q != StIdle);
            bus.op_ready  = op_ready;
            bus.res_valid = (state_q == StDone);
            bus.res_p     = res_p_q;

            // Bubbles put zero on the slice so stale operands never sit on A/B.
            if (hs) begin
                bus.dsp_a = bus.op_a;
                bus.dsp_b = bus.op_b;
            end

            // OPMODE is taken one stage early so the slice OPMODE register holds it
            // during the cycle the product reaches the P input.
            if (active) begin
                bus.dsp_opmode = slot_first_q[LAT-2] ? OPM_FIRST : OPM_ACC;
            end

            bus.dsp_cea      = active;
            bus.dsp_ceb      = active;
            bus.dsp_cem      = active;
            bus.dsp_ceopmode = active;
            bus.dsp_cep      = slot_v_q[LAT-1];
            bus.dsp_rstp     = (state_q == StClr) || abort_hit;
        end
    end

endmodule

// File: tb/tb_dsp_mac_seq.sv
// tb_dsp_mac_seq -- self-checking bench for dsp_mac_seq with a behavioural DSP slice.
//
// Expected sums come from plain signed arithmetic over the operand lists; the slice
// model is a product delay line plus a P register controlled by the DUT enables.
module tb_dsp_mac_seq;

    localparam int          LAT       = 4;
    localparam logic [7:0]  OPM_FIRST = 8'h01;
    localparam logic [7:0]  OPM_ACC   = 8'h09;

    logic clk;
    logic rstn;
    dsp_mac_seq_if bus ();

    dsp_mac_seq #(
        .LAT       (LAT),
        .OPM_FIRST (OPM_FIRST),
        .OPM_ACC   (OPM_ACC)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DSP slice model ----------------
    logic [47:0] pipe [LAT];
    logic [7:0]  opm_q;
    logic [47:0] p_q;

    always @(posedge clk) begin
        if (bus.dsp_cem) begin
            pipe[0] <= 48'(longint'(bus.dsp_a) * longint'(bus.dsp_b));
            for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
        end
        if (bus.dsp_ceopmode) opm_q <= bus.dsp_opmode;
        if (bus.dsp_rstp) p_q <= 48'd0;
        else if (bus.dsp_cep) p_q <= (opm_q[3] ? p_q : 48'd0) + pipe[LAT-1];
    end
    assign bus.dsp_p = p_q;

    // ---------------- activity counters ----------------
    int cep_cnt   = 0;
    int first_cnt = 0;
    int ce_cnt    = 0;

    always @(negedge clk) begin
        if (bus.dsp_cep) cep_cnt <= cep_cnt + 1;
        if (bus.dsp_ceopmode && bus.dsp_opmode == OPM_FIRST) first_cnt <= first_cnt + 1;
        if (bus.dsp_cea || bus.dsp_ceb || bus.dsp_cem || bus.dsp_ceopmode)
            ce_cnt <= ce_cnt + 1;
    end

    // ---------------- checking helpers ----------------
    int errors = 0;
    int checks = 0;

    logic signed [17:0] a_arr [64];
    logic signed [17:0] b_arr [64];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_pair(input logic signed [17:0] a, input logic signed [17:0] b,
                             output bit ok);
        int k;
        bit rdy;
        k  = 0;
        ok = 1'b0;
        bus.op_valid = 1'b1;
        bus.op_a     = a;
        bus.op_b     = b;
        while (!ok && k < 64) begin
            rdy = bus.op_ready;
            step();
            k++;
            if (rdy) ok = 1'b1;
        end
        bus.op_valid = 1'b0;
    endtask

    task automatic start_op(input int n);
        bus.start = 1'b1;
        bus.len   = n[7:0];
        step();
        bus.start = 1'b0;
    endtask

    // One full dot product of n pairs from a_arr/b_arr, gaps of 0..gap_max between pairs.
    task automatic do_op(input int n, input int gap_max);
        longint sum;
        int     c_cep0, c_first0, k, g, d;
        bit     ok;
        sum      = 0;
        c_cep0   = cep_cnt;
        c_first0 = first_cnt;
        start_op(n);
        for (int i = 0; i < n; i++) begin
            if (i > 0 && gap_max > 0) begin
                g = $urandom_range(gap_max, 0);
                repeat (g) step();
            end
            send_pair(a_arr[i], b_arr[i], ok);
            chk("handshake", 64'(ok), 64'd1);
            sum += longint'(a_arr[i]) * longint'(b_arr[i]);
        end
        k = 0;
        while (!bus.res_valid && k < 200) begin
            step();
            k++;
        end
        chk("res_valid", 64'(bus.res_valid), 64'd1);
        chk("latency", 64'(k), 64'(LAT + 1));
        chk("res_p", 64'(bus.res_p), 64'(sum[47:0]));
        chk("cep_count", 64'(cep_cnt - c_cep0), 64'(n));
        chk("first_count", 64'(first_cnt - c_first0), 64'd1);
        d = $urandom_range(3, 0);
        repeat (d) begin
            step();
            chk("res_p_hold", 64'(bus.res_p), 64'(sum[47:0]));
        end
        bus.res_ready = 1'b1;
        step();
        bus.res_ready = 1'b0;
        chk("idle_after_ack", 64'(bus.busy), 64'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int c_ce0, c_cep0, n;
        bit ok;

        rstn          = 1'b0;
        bus.start     = 1'b0;
        bus.len       = 8'd0;
        bus.abort     = 1'b0;
        bus.op_valid  = 1'b0;
        bus.op_a      = '0;
        bus.op_b      = '0;
        bus.res_ready = 1'b0;

        // Reset state.
        repeat (2) step();
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_rstp", 64'(bus.dsp_rstp), 64'd1);
        chk("rst_cea", 64'(bus.dsp_cea), 64'd0);
        chk("rst_res_valid", 64'(bus.res_valid), 64'd0);
        rstn = 1'b1;
        step();
        chk("idle_rstp", 64'(bus.dsp_rstp), 64'd0);
        chk("idle_op_ready", 64'(bus.op_ready), 64'd0);
        chk("idle_res_p", 64'(bus.res_p), 64'd0);

        // Back-to-back pairs: 2*3 + 4*5 + (-1)*7 = 19.
        a_arr[0] = 18'sd2;  b_arr[0] = 18'sd3;
        a_arr[1] = 18'sd4;  b_arr[1] = 18'sd5;
        a_arr[2] = -18'sd1; b_arr[2] = 18'sd7;
        do_op(3, 0);

        // Same pairs with two idle cycles between each.
        c_cep0 = cep_cnt;
        start_op(3);
        for (int i = 0; i < 3; i++) begin
            if (i > 0) repeat (2) step();
            send_pair(a_arr[i], b_arr[i], ok);
            chk("gap_handshake", 64'(ok), 64'd1);
        end
        n = 0;
        while (!bus.res_valid && n < 200) begin
            step();
            n++;
        end
        chk("gap_res_p", 64'(bus.res_p), 64'd19);
        chk("gap_cep3", 64'(cep_cnt - c_cep0), 64'd3);
        bus.res_ready = 1'b1;
        step();
        bus.res_ready = 1'b0;

        // Consecutive operations must not leak into each other: 2 then 25.
        a_arr[0] = 18'sd1; b_arr[0] = 18'sd1;
        a_arr[1] = 18'sd1; b_arr[1] = 18'sd1;
        do_op(2, 0);
        a_arr[0] = 18'sd5; b_arr[0] = 18'sd5;
        do_op(1, 0);

        // Zero-length operation, plus start ignored while in DONE.
        c_ce0  = ce_cnt;
        c_cep0 = cep_cnt;
        start_op(0);
        chk("len0_res_valid", 64'(bus.res_valid), 64'd1);
        chk("len0_res_p", 64'(bus.res_p), 64'd0);
        bus.start = 1'b1;
        bus.len   = 8'd5;
        step();
        bus.start = 1'b0;
        chk("done_ignores_start", 64'(bus.res_valid), 64'd1);
        bus.res_ready = 1'b1;
        step();
        bus.res_ready = 1'b0;
        chk("len0_no_ce", 64'(ce_cnt - c_ce0), 64'd0);
        chk("len0_no_cep", 64'(cep_cnt - c_cep0), 64'd0);
        chk("len0_idle", 64'(bus.busy), 64'd0);

        // Abort after 2 of 4 pairs, colliding with a third handshake.
        start_op(4);
        send_pair(18'sd9, 18'sd9, ok);
        send_pair(18'sd8, 18'sd8, ok);
        bus.op_valid = 1'b1;
        bus.op_a     = 18'sd7;
        bus.op_b     = 18'sd7;
        bus.abort    = 1'b1;
        #1;
        chk("abort_op_ready", 64'(bus.op_ready), 64'd1);
        chk("abort_rstp", 64'(bus.dsp_rstp), 64'd1);
        step();
        bus.abort    = 1'b0;
        bus.op_valid = 1'b0;
        chk("abort_idle", 64'(bus.busy), 64'd0);
        chk("abort_rstp_off", 64'(bus.dsp_rstp), 64'd0);
        n = 0;
        repeat (LAT + 2) begin
            if (bus.res_valid) n++;
            step();
        end
        chk("abort_no_res_valid", 64'(n), 64'd0);
        a_arr[0] = 18'sd3; b_arr[0] = -18'sd4;
        do_op(1, 0);

        // Reset while draining.
        a_arr[0] = 18'sd2;  b_arr[0] = 18'sd3;
        a_arr[1] = 18'sd4;  b_arr[1] = 18'sd5;
        a_arr[2] = -18'sd1; b_arr[2] = 18'sd7;
        start_op(3);
        for (int i = 0; i < 3; i++) send_pair(a_arr[i], b_arr[i], ok);
        step();
        rstn = 1'b0;
        #1;
        chk("drain_rst_busy", 64'(bus.busy), 64'd0);
        chk("drain_rst_cep", 64'(bus.dsp_cep), 64'd0);
        chk("drain_rst_cem", 64'(bus.dsp_cem), 64'd0);
        chk("drain_rst_rstp", 64'(bus.dsp_rstp), 64'd1);
        step();
        rstn = 1'b1;
        #1;
        chk("post_rst_busy", 64'(bus.busy), 64'd0);
        chk("post_rst_rstp", 64'(bus.dsp_rstp), 64'd0);
        n = 0;
        repeat (LAT + 4) begin
            if (bus.res_valid || bus.res_p != 48'd0) n++;
            step();
        end
        chk("post_rst_quiet", 64'(n), 64'd0);

        // Randomized operations against the arithmetic model.
        for (int t = 0; t < 16; t++) begin
            n = $urandom_range(12, 1);
            for (int i = 0; i < n; i++) begin
                a_arr[i] = 18'($urandom);
                b_arr[i] = 18'($urandom);
            end
            do_op(n, (t % 2 == 0) ? 0 : 2);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dsp_mac_seq.md
DSP_MAC_SEQ -- requirements
Module: dsp_mac_seq

Interface
REQ-001 SHALL have parameter LAT, default 4, meaning cycles from an operand pair on DSP_A/DSP_B to its product being loaded into the slice P register (legal 3..8).
REQ-002 SHALL have parameter OPM_FIRST, default 8'h01, meaning the slice OPMODE for the first product (X=M, Z=0, add).
REQ-003 SHALL have parameter OPM_ACC, default 8'h09, meaning the slice OPMODE for later products (X=M, Z=P, add).
REQ-004 SHALL have these ports, one per line (name, direction, width, meaning):
- CLK  in  1  single clock, rising edge.
- RSTN  in  1  reset, synchronous, active-low.
- START  in  1  starts a dot product; sampled in IDLE only.
- LEN  in  8  number of operand pairs; captured when START is accepted.
- ABORT  in  1  cancels the operation in progress.
- BUSY  out  1  high in every state other than IDLE.
- OP_VALID  in  1  operand pair valid.
- OP_READY  out  1  operand pair accepted when OP_VALID and OP_READY are both high.
- OP_A, OP_B  in  18 each  signed operands.
- RES_VALID  out  1  result valid.
- RES_READY  in  1  result consumed when RES_VALID and RES_READY are both high.
- RES_P  out  48  accumulated result.
- DSP_A, DSP_B  out  18 each  slice A and B inputs.
- DSP_OPMODE  out  8  slice OPMODE input (slice OPMODEREG=1).
- DSP_CEA, DSP_CEB, DSP_CEM, DSP_CEOPMODE, DSP_CEP  out  1 each  slice clock enables.
- DSP_RSTP  out  1  slice P reset, active-high.
- DSP_P  in  48  slice P output.

Function
REQ-005 SHALL implement states IDLE, CLR, RUN, DRAIN, DONE.
REQ-006 IDLE: on START, capture LEN. If LEN=0, go to DONE with RES_P=0. Otherwise go to CLR.
REQ-007 CLR SHALL last one cycle, assert DSP_RSTP=1, and load the operand counter CNT=0, then go to RUN.
REQ-008 RUN: OP_READY=1 while CNT<LEN. Each handshake drives DSP_A=OP_A and DSP_B=OP_B for that cycle and increments CNT. With no handshake, DSP_A=DSP_B=0 (bubble).
REQ-009 Each RUN cycle SHALL push a slot {v, first} into a LAT-deep shift register. v=handshake. first=(handshake and CNT==0).
REQ-010 DSP_OPMODE SHALL be driven from slot stage LAT-2: OPM_FIRST if first, else OPM_ACC. This lets the slice OPMODE register align with the product.
REQ-011 DSP_CEP SHALL equal v of slot stage LAT-1. A bubble never updates P.
REQ-012 DSP_CEA, DSP_CEB, DSP_CEM and DSP_CEOPMODE SHALL be 1 in CLR, RUN and DRAIN, and 0 otherwise.
REQ-013 When the LEN-th handshake occurs, the FSM SHALL move to DRAIN on the next edge. OP_READY SHALL be 0 from then on.
REQ-014 DRAIN SHALL push v=0 slots. When the last valid slot leaves stage LAT-1 (P updated), DSP_P SHALL be captured into RES_P on the next edge and the FSM SHALL enter DONE.
REQ-015 Latency: last handshake at edge t gives RES_VALID=1 after edge t+LAT+1.
REQ-016 DONE: RES_VALID=1 and RES_P held stable until RES_READY=1, then return to IDLE. START is ignored outside IDLE.
REQ-017 Arithmetic SHALL be signed 18x18 into a 48-bit accumulate. Overflow wraps modulo 2^48 with no flag.
REQ-018 ABORT in any non-IDLE state SHALL go to IDLE on the next edge. It clears all slots and CNT, drops RES_VALID, and asserts DSP_RSTP=1 for that one cycle.
REQ-019 If ABORT and a handshake occur in the same cycle, ABORT wins: the operand is accepted but discarded.

Reset
REQ-020 RSTN=0 at a rising edge SHALL force IDLE and clear CNT, the slots and RES_P.
REQ-021 During reset all outputs SHALL be 0, except DSP_RSTP=1.
REQ-022 Reset SHALL take priority over ABORT and START. A reset mid-operation discards all work in flight.

Verification
REQ-023 LEN=3 with pairs (2,3),(4,5),(-1,7) sent back-to-back -> RES_P=19, RES_VALID exactly LAT+1 cycles after the third handshake.
REQ-024 LEN=3, same pairs, with OP_VALID low for 2 cycles between each pair -> RES_P=19. DSP_CEP high exactly 3 cycles, and DSP_OPMODE=OPM_FIRST exactly once.
REQ-025 Two back-to-back operations, LEN=2 with (1,1),(1,1) then LEN=1 with (5,5) -> RES_P=2, then RES_P=25; the first result does not leak into the second.
REQ-026 LEN=0 -> RES_VALID one cycle after START with RES_P=0, and no DSP_CE asserted.
REQ-027 ABORT after 2 of 4 pairs -> IDLE next cycle, DSP_RSTP pulse, no RES_VALID; a following LEN=1 with (3,-4) -> RES_P=-12.
REQ-028 RSTN low for one cycle during DRAIN, with RES_READY held low in DONE afterwards -> IDLE with all outputs 0; RES_VALID stays 0 and RES_P stays 0 until the next START.
